// File: rtl/gates_pkg.sv
// Shared types and constants for the gate-unit sequencer and its golden model.
package gates_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned NUM_COMBOS = 4;
  localparam int unsigned Y_W        = 3;

  // Bit positions of each gate output inside y
  localparam int unsigned Y_AND = 2;
  localparam int unsigned Y_OR  = 1;
  localparam int unsigned Y_NOT = 0;

endpackage

// File: rtl/gates_expect.sv
// Golden model of the 3-output gate unit: combo = {a,b} -> {AND, OR, NOT a}.
module gates_expect
  import gates_pkg::*;
(
  input  logic [1:0]     combo,
  output logic [Y_W-1:0] exp
);

  // Truth table of the healthy gate unit
  always_comb begin
    exp        = '0;
    exp[Y_AND] = combo[1] & combo[0];
    exp[Y_OR]  = combo[1] | combo[0];
    exp[Y_NOT] = ~combo[1];
  end

endmodule

// File: rtl/gates_test_sequencer.sv
// Self-checking sweep of all four {a,b} input combinations through an external gate unit.
// Each combination is held for HOLD settle cycles, then y_in is compared to the golden model.
module gates_test_sequencer
  import gates_pkg::*;
#(
  parameter int unsigned HOLD = 4  // settle cycles per combination, 1..15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Y_W-1:0] y_in,
  output logic           a,
  output logic           b,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2:0]     err_count,
  output logic [3:0]     fail_vec
);

  localparam int unsigned    HcW      = $clog2(HOLD + 1);
  localparam logic [HcW-1:0] HoldLast = HcW'(HOLD - 1);
  localparam logic [1:0]     LastCombo = 2'(NUM_COMBOS - 1);

  state_e         state_q;
  logic [1:0]     combo_q;
  logic [HcW-1:0] hold_cnt_q;
  logic           a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0]     err_count_q;
  logic [3:0]     fail_vec_q;

  logic [Y_W-1:0] exp_y;
  logic           mismatch;
  logic [1:0]     combo_nxt;

  gates_expect u_expect (
    .combo (combo_q),
    .exp   (exp_y)
  );

  assign mismatch  = (y_in != exp_y);
  assign combo_nxt = combo_q + 2'd1;

  // Sweep FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      combo_q     <= '0;
      hold_cnt_q  <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      fail_vec_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Results from the previous sweep hold here until a new start
          if (start) begin
            state_q     <= StDrive;
            combo_q     <= '0;
            hold_cnt_q  <= '0;
            err_count_q <= '0;
            fail_vec_q  <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
          end
        end
        StDrive: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HoldLast) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (mismatch) begin
            err_count_q         <= err_count_q + 3'd1;
            fail_vec_q[combo_q] <= 1'b1;
          end
          if (combo_q == LastCombo) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            // Include a mismatch found in this final check
            pass_q  <= (err_count_q == 3'd0) && !mismatch;
          end else begin
            state_q    <= StDrive;
            combo_q    <= combo_nxt;
            hold_cnt_q <= '0;
            a_q        <= combo_nxt[1];
            b_q        <= combo_nxt[0];
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_gates_test_sequencer.sv
// Bench for gates_test_sequencer: two instances (HOLD=4 and HOLD=1) driving a modelled gate
// unit with stuck-at faults and junk on y_in outside the check cycle.
module tb_gates_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sel, glitch;
  logic [2:0] f0, f1, junk;

  logic       a4, b4, busy4, done4, pass4;
  logic [2:0] ec4, y4;
  logic [3:0] fv4;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] ec1, y1;
  logic [3:0] fv1;

  logic       oa, ob, obusy, odone, opass;
  logic [2:0] oec;
  logic [3:0] ofv;

  int errors = 0;
  int checks = 0;

  // Gate unit with stuck-at-0 (f0) and stuck-at-1 (f1) masks
  function automatic logic [2:0] unit(input logic ua, input logic ub);
    return {ua & ub, ua | ub, ~ua};
  endfunction

  assign y4 = glitch ? junk : ((unit(a4, b4) & ~f0) | f1);
  assign y1 = glitch ? junk : ((unit(a1, b1) & ~f0) | f1);

  gates_test_sequencer #(.HOLD(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start & ~sel),
    .y_in      (y4),
    .a         (a4),
    .b         (b4),
    .busy      (busy4),
    .done      (done4),
    .pass      (pass4),
    .err_count (ec4),
    .fail_vec  (fv4)
  );

  gates_test_sequencer #(.HOLD(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start & sel),
    .y_in      (y1),
    .a         (a1),
    .b         (b1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (ec1),
    .fail_vec  (fv1)
  );

  assign oa    = sel ? a1 : a4;
  assign ob    = sel ? b1 : b4;
  assign obusy = sel ? busy1 : busy4;
  assign odone = sel ? done1 : done4;
  assign opass = sel ? pass1 : pass4;
  assign oec   = sel ? ec1 : ec4;
  assign ofv   = sel ? fv1 : fv4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: which combinations disagree with the truth table under the given faults
  function automatic logic [3:0] ref_fails(input logic [2:0] z, input logic [2:0] o);
    logic [3:0] fv;
    logic [2:0] good, bad;
    fv = '0;
    for (int i = 0; i < 4; i++) begin
      good  = {i == 3, i != 0, i < 2};
      bad   = (good & ~z) | o;
      fv[i] = (bad != good);
    end
    return fv;
  endfunction

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return 3'(n);
  endfunction

  // One sweep checked every cycle; returns at cycle total+3 (23 for HOLD=4)
  task automatic sweep(input string name, input int h, input int repulse_at, input int rst_at,
                       input logic [2:0] fz, input logic [2:0] fo);
    logic [3:0]  fv, pfv;
    logic [2:0]  ec, pec;
    logic        ps;
    logic [12:0] exp_v, obs_v;
    int          total, k;
    f0    = fz;
    f1    = fo;
    fv    = ref_fails(fz, fo);
    ec    = count_ones(fv);
    ps    = (ec == 3'd0);
    total = 4 * (h + 1);
    start = 1'b1;
    glitch = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      start  = (c == repulse_at);
      rst    = (c == rst_at);
      glitch = (c <= total) && (((c - 1) % (h + 1)) != h);
      junk   = 3'($urandom);
      if (c <= total) begin
        k     = (c - 1) / (h + 1);
        pfv   = fv & 4'((1 << k) - 1);
        pec   = count_ones(pfv);
        exp_v = {2'(k), 1'b1, 1'b0, 1'b0, pec, pfv};
      end else if (c == total + 1) begin
        exp_v = {4'b0001, ps, ec, fv};
      end else begin
        exp_v = {4'b0000, ps, ec, fv};
      end
      obs_v = {oa, ob, obusy, odone, opass, oec, ofv};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d {a,b,busy,done,pass,err,fail}: got %b want %b",
                 name, c, obs_v, exp_v);
      end
      tick();
      if (rst) begin
        rst    = 1'b0;
        glitch = 1'b0;
        obs_v  = {oa, ob, obusy, odone, opass, oec, ofv};
        checks++;
        if (obs_v !== 13'd0) begin
          errors++;
          $display("FAIL %s after_rst cycle %0d: got %b want %b", name, c + 1, obs_v, 13'd0);
        end
        break;
      end
    end
    start  = 1'b0;
    glitch = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; sel = 1'b0; glitch = 1'b0;
    f0 = '0; f1 = '0; junk = '0;
    tick();
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({a4, b4, busy4, done4, pass4, ec4, fv4} !== 13'd0) begin
      errors++;
      $display("FAIL reset_h4: got %b want %b", {a4, b4, busy4, done4, pass4, ec4, fv4}, 13'd0);
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, ec1, fv1} !== 13'd0) begin
      errors++;
      $display("FAIL reset_h1: got %b want %b", {a1, b1, busy1, done1, pass1, ec1, fv1}, 13'd0);
    end
    tick();
  endtask

  task automatic test_healthy();
    sel = 1'b0;
    sweep("healthy", 4, 0, 0, 3'b000, 3'b000);
  endtask

  task automatic test_stuck_faults();
    sel = 1'b0;
    sweep("not_stuck0", 4, 0, 0, 3'b001, 3'b000);
    sweep("and_stuck1", 4, 0, 0, 3'b000, 3'b100);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    sweep("repulse", 4, 8, 0, 3'b001, 3'b000);
    sweep("rerun", 4, 0, 0, 3'b001, 3'b000);
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    sweep("mid_rst", 4, 0, 12, 3'b010, 3'b000);
    tick();
    sweep("after_rst", 4, 0, 0, 3'b000, 3'b000);
  endtask

  task automatic test_hold1();
    sel = 1'b1;
    sweep("hold1", 1, 0, 0, 3'b000, 3'b000);
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] z, o;
    for (int n = 0; n < 8; n++) begin
      sel = 1'($urandom);
      z   = 3'($urandom);
      o   = 3'($urandom);
      sweep("random", sel ? 1 : 4, 0, 0, z, o);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_healthy();
    test_stuck_faults();
    test_back_to_back();
    test_mid_reset();
    test_hold1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
